// File: rtl/pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pc_unit                                                     |
// | Purpose  : Fetch program counter with prioritised next-PC selection    |
// |            (trap, mret, redirect, stall, RAS prediction, PC+4),        |
// |            exception-PC capture, misaligned-target flag and a small    |
// |            circular return-address stack.                              |
// | Ports    : clk, rst_n          - clock, async active-low reset         |
// |            stall               - hold PC, squash RAS ops               |
// |            trap_valid/vector   - enter trap handler, capture epc       |
// |            mret_valid          - return to epc                         |
// |            redirect_valid/tgt  - resolved branch/jump                  |
// |            ras_push/ras_pop    - call/return hints for pc_current      |
// |            pc_current, epc     - fetch PC, exception PC                |
// |            misalign_fault      - 1-cycle pulse, last target unaligned  |
// |            ras_count/ras_empty - RAS occupancy                         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pc_unit #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = {XLEN{1'b0}},
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           trap_valid,
  input  logic [XLEN-1:0]                trap_vector,
  input  logic                           mret_valid,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_target,
  input  logic                           ras_push,
  input  logic                           ras_pop,
  output logic [XLEN-1:0]                pc_current,
  output logic [XLEN-1:0]                epc,
  output logic                           misalign_fault,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty
);

  localparam int unsigned                c_PTR_W  = $clog2(RAS_DEPTH);
  localparam int unsigned                c_CNT_W  = c_PTR_W + 1;
  localparam logic [XLEN-1:0]            c_PC_INC = XLEN'(4);
  localparam logic [c_CNT_W-1:0]         c_DEPTH  = c_CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_epc;
  logic               r_misalign;
  logic [c_CNT_W-1:0] r_ras_count;
  logic               r_ras_empty;
  logic [c_PTR_W-1:0] r_ras_ptr;   // next free slot; top of stack is r_ras_ptr-1
  logic [XLEN-1:0]    r_ras [RAS_DEPTH];

  logic [XLEN-1:0]    w_pc_seq;
  logic [c_PTR_W-1:0] w_top_idx;
  logic [XLEN-1:0]    w_target;
  logic               w_load_target;
  logic               w_do_push;
  logic               w_do_pop;
  logic [XLEN-1:0]    w_pc_next;
  logic               w_misalign_next;
  logic [c_CNT_W-1:0] w_count_next;
  logic [c_PTR_W-1:0] w_ptr_next;
  logic               w_ras_we;
  logic [c_PTR_W-1:0] w_ras_widx;

  assign w_pc_seq  = r_pc + c_PC_INC;
  assign w_top_idx = r_ras_ptr - c_PTR_W'(1);

  // Next-PC priority select
  always_comb begin
    w_target        = '0;
    w_load_target   = 1'b0;
    w_do_push       = 1'b0;
    w_do_pop        = 1'b0;
    w_pc_next       = w_pc_seq;
    w_misalign_next = 1'b0;
    if (trap_valid) begin
      w_target      = trap_vector;
      w_load_target = 1'b1;
    end else if (mret_valid) begin
      w_target      = r_epc;
      w_load_target = 1'b1;
    end else if (redirect_valid) begin
      w_target      = redirect_target;
      w_load_target = 1'b1;
    end else if (stall) begin
      w_pc_next     = r_pc;
    end else begin
      // RAS operations only survive when no higher-priority source fires
      w_do_push = ras_push;
      w_do_pop  = ras_pop && !r_ras_empty;
      if (w_do_pop) begin
        w_pc_next = r_ras[w_top_idx];
      end
    end
    if (w_load_target) begin
      w_pc_next       = {w_target[XLEN-1:2], 2'b00};
      w_misalign_next = |w_target[1:0];
    end
  end

  // RAS pointer/count update. A simultaneous push+pop rewrites the top
  // in place, so neither pointer nor count moves.
  always_comb begin
    w_count_next = r_ras_count;
    w_ptr_next   = r_ras_ptr;
    w_ras_we     = 1'b0;
    w_ras_widx   = r_ras_ptr;
    if (w_do_push && w_do_pop) begin
      w_ras_we   = 1'b1;
      w_ras_widx = w_top_idx;
    end else if (w_do_push) begin
      w_ras_we   = 1'b1;
      w_ptr_next = r_ras_ptr + c_PTR_W'(1);
      if (r_ras_count != c_DEPTH) begin
        w_count_next = r_ras_count + c_CNT_W'(1);
      end
    end else if (w_do_pop) begin
      w_ptr_next   = w_top_idx;
      w_count_next = r_ras_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_VECTOR;
      r_epc       <= '0;
      r_misalign  <= 1'b0;
      r_ras_count <= '0;
      r_ras_empty <= 1'b1;
      r_ras_ptr   <= '0;
    end else begin
      r_pc        <= w_pc_next;
      r_misalign  <= w_misalign_next;
      r_ras_count <= w_count_next;
      r_ras_empty <= (w_count_next == '0);
      r_ras_ptr   <= w_ptr_next;
      if (trap_valid) begin
        r_epc <= r_pc;
      end
    end
  end

  // Entry storage is not reset; validity is tracked by r_ras_count
  always_ff @(posedge clk) begin
    if (w_ras_we) begin
      r_ras[w_ras_widx] <= w_pc_seq;
    end
  end

  assign pc_current     = r_pc;
  assign epc            = r_epc;
  assign misalign_fault = r_misalign;
  assign ras_count      = r_ras_count;
  assign ras_empty      = r_ras_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_pc_unit                                                  |
// | Purpose  : Directed, table-driven self-checking bench for pc_unit      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        mret_valid;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] pc_current;
  logic [31:0] epc;
  logic        misalign_fault;
  logic [2:0]  ras_count;
  logic        ras_empty;

  int checks;
  int errors;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0100),
    .RAS_DEPTH    (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .mret_valid      (mret_valid),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ras_push        (ras_push),
    .ras_pop         (ras_pop),
    .pc_current      (pc_current),
    .epc             (epc),
    .misalign_fault  (misalign_fault),
    .ras_count       (ras_count),
    .ras_empty       (ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        trap;
    logic [31:0] tv;
    logic        mret;
    logic        redir;
    logic [31:0] rt;
    logic        push;
    logic        pop;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_mis;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic t, input logic [31:0] tv,
                     input logic m, input logic r, input logic [31:0] rt,
                     input logic pu, input logic po, input logic [31:0] pc,
                     input logic [31:0] ep, input logic mi, input logic [2:0] cn);
    vec_t v;
    v.stall = s;  v.trap = t;  v.tv = tv;  v.mret = m;  v.redir = r;  v.rt = rt;
    v.push = pu;  v.pop = po;  v.exp_pc = pc;  v.exp_epc = ep;  v.exp_mis = mi;
    v.exp_cnt = cn;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ep,
                           input logic mi, input logic [2:0] cn);
    check({tag, " pc"},    pc_current, pc);
    check({tag, " epc"},   epc, ep);
    check({tag, " mis"},   {31'd0, misalign_fault}, {31'd0, mi});
    check({tag, " cnt"},   {29'd0, ras_count}, {29'd0, cn});
    check({tag, " empty"}, {31'd0, ras_empty}, {31'd0, (cn == 3'd0)});
  endtask

  task automatic idle_inputs();
    stall = 0; trap_valid = 0; trap_vector = '0; mret_valid = 0;
    redirect_valid = 0; redirect_target = '0; ras_push = 0; ras_pop = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b0;

    //   st tr tv            mr rd rt            pu po exp_pc        exp_epc       mi cnt
    // sequential fetch from reset vector
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_0104, 32'h0,        0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_0108, 32'h0,        0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_010C, 32'h0,        0, 0);
    // wrap and stall
    add(0, 0, 32'h0,         0, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 32'h0,       0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'hFFFF_FFFC, 32'h0,        0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_0000, 32'h0,        0, 0);
    add(1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_0000, 32'h0,        0, 0);
    add(1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_0000, 32'h0,        0, 0);
    // trap beats redirect, mret, misaligned redirect pulse
    add(0, 0, 32'h0,         0, 1, 32'h200,      0, 0, 32'h0000_0200, 32'h0,        0, 0);
    add(0, 1, 32'h8000_0000, 0, 1, 32'h300,      0, 0, 32'h8000_0000, 32'h200,      0, 0);
    add(0, 0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0000_0200, 32'h200,      0, 0);
    add(0, 0, 32'h0,         0, 1, 32'h306,      0, 0, 32'h0000_0304, 32'h200,      1, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_0308, 32'h200,      0, 0);
    // call/return
    add(0, 0, 32'h0,         0, 1, 32'h400,      0, 0, 32'h0000_0400, 32'h200,      0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0404, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 1, 32'h500,      0, 0, 32'h0000_0500, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0504, 32'h200,      0, 2);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0504, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0404, 32'h200,      0, 0);
    // overflow: five calls into a 4-deep RAS
    add(0, 0, 32'h0,         0, 1, 32'h10,       0, 0, 32'h0000_0010, 32'h200,      0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0014, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 1, 32'h20,       0, 0, 32'h0000_0020, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0024, 32'h200,      0, 2);
    add(0, 0, 32'h0,         0, 1, 32'h30,       0, 0, 32'h0000_0030, 32'h200,      0, 2);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0034, 32'h200,      0, 3);
    add(0, 0, 32'h0,         0, 1, 32'h40,       0, 0, 32'h0000_0040, 32'h200,      0, 3);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0044, 32'h200,      0, 4);
    add(0, 0, 32'h0,         0, 1, 32'h50,       0, 0, 32'h0000_0050, 32'h200,      0, 4);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0054, 32'h200,      0, 4);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0054, 32'h200,      0, 3);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0044, 32'h200,      0, 2);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0034, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0024, 32'h200,      0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0028, 32'h200,      0, 0);
    // squashed pushes, simultaneous push+pop
    add(0, 0, 32'h0,         0, 1, 32'h40,       0, 0, 32'h0000_0040, 32'h200,      0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0044, 32'h200,      0, 1);
    add(1, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'h0000_0044, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 1, 32'h60,       1, 0, 32'h0000_0060, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'h0000_0044, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0064, 32'h200,      0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'h0000_0068, 32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 1, 32'h0000_0068, 32'h200,      0, 0);
    // misaligned trap vector, trap beats mret
    add(0, 1, 32'h0000_1003, 0, 0, 32'h0,        0, 0, 32'h0000_1000, 32'h68,       1, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0000_1004, 32'h68,       0, 0);
    add(0, 1, 32'h0000_2000, 1, 0, 32'h0,        0, 0, 32'h0000_2000, 32'h1004,     0, 0);
    add(0, 0, 32'h0,         1, 0, 32'h0,        0, 0, 32'h0000_1004, 32'h1004,     0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h100, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("first", 32'h104, 32'h0, 1'b0, 3'd0);
    // hold in reset once more so the table starts from 0x100
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // the edge above already advanced once; re-synchronise with the table
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check_all("resync", 32'h100, 32'h0, 1'b0, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      stall           = vecs[i].stall;
      trap_valid      = vecs[i].trap;
      trap_vector     = vecs[i].tv;
      mret_valid      = vecs[i].mret;
      redirect_valid  = vecs[i].redir;
      redirect_target = vecs[i].rt;
      ras_push        = vecs[i].push;
      ras_pop         = vecs[i].pop;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_epc,
                vecs[i].exp_mis, vecs[i].exp_cnt);
    end
    idle_inputs();

    // asynchronous reset in the middle of a cycle, with state built up
    redirect_valid = 1; redirect_target = 32'h0000_0703;
    @(posedge clk); #1;
    redirect_valid = 0; ras_push = 1;
    @(posedge clk); #1;
    ras_push = 0;
    check_all("pre_rst", 32'h0000_0704, 32'h1004, 1'b0, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h100, 32'h0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst", 32'h104, 32'h0, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
